layer_mixer: RTL and testbench
==============================

Name: layer_mixer

Overview:
- Final video compositing stage, directly downstream of the tilemap layer.
- Each pixel clock it takes RGBA from the tilemap, charmap and sprite layers, picks the top visible layer by a CPU-programmed priority, falls back to a programmable background colour, and applies a global brightness level.
- A frame-stepped fade state machine (fade out / fade in) drives the brightness level.
- Output feeds the video scaler/DAC path with blanking re-aligned to the pipeline latency.

Parameters:
- FADE_STEP_FRAMES, 2, vblank rising edges between brightness steps (1..15).
- MAX_LEVEL, 8, full-brightness level; scale = level/8.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pause  in  1  freezes the fade frame counter; pixel path keeps running.
- hblank  in  1  horizontal blank, aligned with layer inputs.
- vblank  in  1  vertical blank, aligned with layer inputs.
- addr  in  2  control register index.
- data_in  in  8  CPU write data.
- write  in  1  CPU write strobe, one cycle.
- mixer_data_out  out  8  combinational readback of register[addr].
- tilemap_r / tilemap_g / tilemap_b  in  8 each  tilemap layer colour.
- tilemap_a  in  1  tilemap layer opaque flag.
- charmap_r / charmap_g / charmap_b  in  8 each  charmap layer colour.
- charmap_a  in  1  charmap layer opaque flag.
- sprite_r / sprite_g / sprite_b  in  8 each  sprite layer colour.
- sprite_a  in  1  sprite layer opaque flag.
- video_r / video_g / video_b  out  8 each  mixed, scaled colour (registered).
- video_hblank / video_vblank  out  1 each  blanking delayed to match colour.

Behaviour:
- Reset (async assert, sync-safe release):
  - reg0=0x07, reg1=0x00, reg2=0x00, level=MAX_LEVEL, fade state IDLE, frame counter 0.
  - All video outputs 0; both pipeline stages cleared.
- Register map:
  - reg0: bit0 tilemap enable, bit1 charmap enable, bit2 sprite enable, bit3 tilemap_over_sprite, bits7:4 read 0.
  - reg1: background colour RGB332; expand to 8 bits by replicating MSBs (R={b7:5,b7:5,b7:6}, same for G; B={b1:0 repeated 4x}).
  - reg2: fade command. 0 idle, 1 fade out, 2 fade in. Other values are stored but do nothing.
  - reg3: brightness level 0..MAX_LEVEL. Reads the live level.
- Writes:
  - reg0/reg1 take effect on the next pixel entering stage 1.
  - reg2 write is ignored (register unchanged) while fade state is not IDLE.
  - reg3 write is ignored while fading. When IDLE it sets level = min(data_in, MAX_LEVEL).
- Pixel pipeline, latency 2 clocks, new pixel every clock:
  - Stage 1: select a layer. A layer is visible when enabled and its _a=1.
  - Default priority, top to bottom: charmap > sprite > tilemap > background.
  - With tilemap_over_sprite=1: charmap > tilemap > sprite > background.
  - Stage 1 also registers hblank/vblank.
  - Stage 2: each channel = (c * level) >> 3, with an 8x4 product truncated to 8 bits. level=8 passes c unchanged; level=0 gives 0.
  - During stage-2 blanking (either blank flag high) the RGB outputs are forced to 0.
- Fade FSM:
  - IDLE: on a write of reg2=1 go to FADE_OUT; reg2=2 goes to FADE_IN. Frame counter cleared.
  - Start condition: if already at the target (out with level=0, in with level=MAX_LEVEL), return to IDLE next cycle and clear reg2.
  - FADE_OUT/FADE_IN: on each vblank rising edge with pause=0, increment the frame counter.
  - When the counter reaches FADE_STEP_FRAMES, clear it and step the level by 1 (down for out, up for in).
  - When the level reaches its target, go to IDLE and clear reg2 to 0 in the same cycle.
  - A command write on the same cycle as a vblank edge starts the fade; that edge is not counted.
  - pause=1 drops vblank edges entirely; they are not deferred.
- Edge detection: vblank rising edge = vblank & ~vblank_q, with vblank_q a registered copy.
- Reset mid-fade returns immediately to IDLE with level=MAX_LEVEL.

Test Plan:
- Reset -> video_* 0; reg0 reads 0x07; reg3 reads 8. Tilemap only, a=1, rgb=(0x80,0x40,0x20), no blank -> same rgb on video_* exactly 2 clocks later.
- Priority, tilemap a=1 red 0xFF and sprite a=1 green 0xFF:
  - reg0=0x07 -> output green.
  - reg0=0x0F -> output red.
  - charmap a=1 blue 0xFF -> blue in both cases.
- All layers a=0, reg1=0xE0 -> video=(0xFF,0x00,0x00). reg0=0x00 with layers opaque -> background.
- Level: reg3=4, input 0xFF -> 0x7F. reg3=0 -> 0x00. reg3=12 -> readback 8, output unchanged.
- Fade out with FADE_STEP_FRAMES=2 -> level 7 after vblank edge 2, 0 after edge 16, then reg2 reads 0. Pause held over 3 edges -> step delayed by exactly 3 edges.
- reg2=2 and reg3=3 written mid-fade -> both ignored. Assert reset_n low mid-fade -> IDLE, level 8, outputs 0 without a clock edge.

Source files
------------

// File: rtl/layer_mixer_if.sv
// CPU control-register bus for layer_mixer: register index, write data/strobe
// and combinational readback. The CPU side uses master, the mixer uses slave.
interface layer_mixer_if;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic       write;
  logic [7:0] mixer_data_out;

  modport master (
    output addr,
    output data_in,
    output write,
    input  mixer_data_out
  );

  modport slave (
    input  addr,
    input  data_in,
    input  write,
    output mixer_data_out
  );
endinterface

// File: rtl/layer_mixer.sv
// Final compositing stage: per-pixel layer priority select, background fallback,
// global brightness scaling and a frame-stepped fade engine driving the level.
module layer_mixer #(
  parameter int FADE_STEP_FRAMES = 2,
  parameter int MAX_LEVEL        = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pause,
  input  logic       hblank,
  input  logic       vblank,
  layer_mixer_if.slave bus,
  input  logic [7:0] tilemap_r,
  input  logic [7:0] tilemap_g,
  input  logic [7:0] tilemap_b,
  input  logic       tilemap_a,
  input  logic [7:0] charmap_r,
  input  logic [7:0] charmap_g,
  input  logic [7:0] charmap_b,
  input  logic       charmap_a,
  input  logic [7:0] sprite_r,
  input  logic [7:0] sprite_g,
  input  logic [7:0] sprite_b,
  input  logic       sprite_a,
  output logic [7:0] video_r,
  output logic [7:0] video_g,
  output logic [7:0] video_b,
  output logic       video_hblank,
  output logic       video_vblank
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_FADE_IN  = 2'd2;

  localparam logic [3:0] MAX_L    = 4'(MAX_LEVEL);
  localparam logic [3:0] STEP     = 4'(FADE_STEP_FRAMES);
  localparam logic [3:0] STEP_END = STEP - 4'd1;

  // Control state
  logic [3:0] reg0;
  logic [7:0] reg1;
  logic [7:0] reg2;
  logic [3:0] level;
  logic [1:0] state;
  logic [3:0] frame_cnt;
  logic       vblank_q;
  logic       vb_edge;

  // Pipeline state
  logic [7:0] s1_r, s1_g, s1_b;
  logic       s1_hblank, s1_vblank;

  logic       wr0, wr1, wr2, wr3;
  logic [3:0] wr_level;

  assign wr0 = bus.write && (bus.addr == 2'd0);
  assign wr1 = bus.write && (bus.addr == 2'd1);
  assign wr2 = bus.write && (bus.addr == 2'd2);
  assign wr3 = bus.write && (bus.addr == 2'd3);

  assign wr_level = (bus.data_in > {4'b0000, MAX_L}) ? MAX_L : bus.data_in[3:0];

  // Paused frames are discarded, not deferred
  assign vb_edge = vblank && !vblank_q && !pause;

  always_comb begin
    bus.mixer_data_out = '0;
    case (bus.addr)
      2'd0:    bus.mixer_data_out = {4'b0000, reg0};
      2'd1:    bus.mixer_data_out = reg1;
      2'd2:    bus.mixer_data_out = reg2;
      default: bus.mixer_data_out = {4'b0000, level};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg0      <= 4'h7;
      reg1      <= '0;
      reg2      <= '0;
      level     <= MAX_L;
      state     <= ST_IDLE;
      frame_cnt <= '0;
      vblank_q  <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (wr0) reg0 <= bus.data_in[3:0];
      if (wr1) reg1 <= bus.data_in;

      case (state)
        ST_IDLE: begin
          if (wr2) begin
            reg2      <= bus.data_in;
            frame_cnt <= '0;
            if (bus.data_in == 8'd1)      state <= ST_FADE_OUT;
            else if (bus.data_in == 8'd2) state <= ST_FADE_IN;
          end else if (wr3) begin
            level <= wr_level;
          end
        end

        // Target check first so a fade started at its target ends next cycle
        ST_FADE_OUT: begin
          if (level == '0) begin
            state <= ST_IDLE;
            reg2  <= '0;
          end else if (vb_edge) begin
            if (frame_cnt == STEP_END) begin
              frame_cnt <= '0;
              level     <= level - 4'd1;
              if (level == 4'd1) begin
                state <= ST_IDLE;
                reg2  <= '0;
              end
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end
        end

        ST_FADE_IN: begin
          if (level >= MAX_L) begin
            state <= ST_IDLE;
            reg2  <= '0;
          end else if (vb_edge) begin
            if (frame_cnt == STEP_END) begin
              frame_cnt <= '0;
              level     <= level + 4'd1;
              if (level == MAX_L - 4'd1) begin
                state <= ST_IDLE;
                reg2  <= '0;
              end
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: layer visibility and priority
  logic        tm_vis, cm_vis, sp_vis;
  logic [23:0] bg_rgb;
  logic [23:0] sel_rgb;

  assign tm_vis = reg0[0] && tilemap_a;
  assign cm_vis = reg0[1] && charmap_a;
  assign sp_vis = reg0[2] && sprite_a;

  assign bg_rgb = {reg1[7:5], reg1[7:5], reg1[7:6],
                   reg1[4:2], reg1[4:2], reg1[4:3],
                   {4{reg1[1:0]}}};

  always_comb begin
    sel_rgb = bg_rgb;
    if (cm_vis)
      sel_rgb = {charmap_r, charmap_g, charmap_b};
    else if (reg0[3] && tm_vis)
      sel_rgb = {tilemap_r, tilemap_g, tilemap_b};
    else if (sp_vis)
      sel_rgb = {sprite_r, sprite_g, sprite_b};
    else if (tm_vis)
      sel_rgb = {tilemap_r, tilemap_g, tilemap_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s1_hblank <= 1'b0;
      s1_vblank <= 1'b0;
    end else begin
      s1_r      <= sel_rgb[23:16];
      s1_g      <= sel_rgb[15:8];
      s1_b      <= sel_rgb[7:0];
      s1_hblank <= hblank;
      s1_vblank <= vblank;
    end
  end

  // Stage 2: brightness scale (c * level) >> 3, truncated to 8 bits
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] lvl);
    logic [11:0] prod;
    prod = {4'b0000, c} * {8'h00, lvl};
    return 8'(prod >> 3);
  endfunction

  logic s1_blank;
  assign s1_blank = s1_hblank || s1_vblank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      video_r      <= '0;
      video_g      <= '0;
      video_b      <= '0;
      video_hblank <= 1'b0;
      video_vblank <= 1'b0;
    end else begin
      video_r      <= s1_blank ? 8'h00 : scale(s1_r, level);
      video_g      <= s1_blank ? 8'h00 : scale(s1_g, level);
      video_b      <= s1_blank ? 8'h00 : scale(s1_b, level);
      video_hblank <= s1_hblank;
      video_vblank <= s1_vblank;
    end
  end

endmodule

// File: tb/tb_layer_mixer.sv
// Scoreboard bench for layer_mixer: expected pixels queued at drive time and
// compared two clocks later; fade engine checked through register readback.
module tb_layer_mixer;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hb;
    logic       vb;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic pause   = 1'b0;
  logic hblank  = 1'b0;
  logic vblank  = 1'b0;
  logic [7:0] tm_r = '0, tm_g = '0, tm_b = '0;
  logic [7:0] cm_r = '0, cm_g = '0, cm_b = '0;
  logic [7:0] sp_r = '0, sp_g = '0, sp_b = '0;
  logic tm_a = 1'b0, cm_a = 1'b0, sp_a = 1'b0;
  logic [7:0] video_r, video_g, video_b;
  logic video_hblank, video_vblank;

  layer_mixer_if bus ();

  layer_mixer #(.FADE_STEP_FRAMES(2), .MAX_LEVEL(8)) dut (
    .clk(clk), .reset_n(reset_n), .pause(pause), .hblank(hblank), .vblank(vblank),
    .bus(bus),
    .tilemap_r(tm_r), .tilemap_g(tm_g), .tilemap_b(tm_b), .tilemap_a(tm_a),
    .charmap_r(cm_r), .charmap_g(cm_g), .charmap_b(cm_b), .charmap_a(cm_a),
    .sprite_r(sp_r), .sprite_g(sp_g), .sprite_b(sp_b), .sprite_a(sp_a),
    .video_r(video_r), .video_g(video_g), .video_b(video_b),
    .video_hblank(video_hblank), .video_vblank(video_vblank)
  );

  int checks = 0;
  int errors = 0;
  pix_t exp_q[$];

  // Reference model state
  logic [3:0] m_reg0 = 4'h7;
  logic [7:0] m_reg1 = 8'h00;
  int         m_level = 8;

  function automatic pix_t model_pixel();
    pix_t p;
    logic [23:0] c;
    logic [2:0] r3, g3;
    logic [1:0] b2;
    r3 = m_reg1[7:5];
    g3 = m_reg1[4:2];
    b2 = m_reg1[1:0];
    c = {({r3, 5'b0} | {3'b0, r3, 2'b0} | {6'b0, r3[2:1]}),
         ({g3, 5'b0} | {3'b0, g3, 2'b0} | {6'b0, g3[2:1]}),
         8'({6'b0, b2} * 8'h55)};
    if (m_reg0[1] && cm_a) c = {cm_r, cm_g, cm_b};
    else if (m_reg0[3] && m_reg0[0] && tm_a) c = {tm_r, tm_g, tm_b};
    else if (m_reg0[2] && sp_a) c = {sp_r, sp_g, sp_b};
    else if (m_reg0[0] && tm_a) c = {tm_r, tm_g, tm_b};
    p.r = 8'((int'(c[23:16]) * m_level) / 8);
    p.g = 8'((int'(c[15:8]) * m_level) / 8);
    p.b = 8'((int'(c[7:0]) * m_level) / 8);
    if (hblank || vblank) begin
      p.r = 8'h00; p.g = 8'h00; p.b = 8'h00;
    end
    p.hb = hblank;
    p.vb = vblank;
    return p;
  endfunction

  task automatic set_layers(input logic [23:0] t, input logic ta, input logic [23:0] ch,
                            input logic ca, input logic [23:0] s, input logic sa,
                            input logic hb, input logic vb);
    {tm_r, tm_g, tm_b} = t;  tm_a = ta;
    {cm_r, cm_g, cm_b} = ch; cm_a = ca;
    {sp_r, sp_g, sp_b} = s;  sp_a = sa;
    hblank = hb; vblank = vb;
  endtask

  task automatic set_random_layers();
    set_layers(24'($urandom), 1'($urandom), 24'($urandom), 1'($urandom),
               24'($urandom), 1'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.data_in = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.addr = a;
    #1 d = bus.mixer_data_out;
  endtask

  task automatic vblank_pulse();
    @(negedge clk); vblank = 1'b1;
    @(negedge clk); vblank = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (2) @(negedge clk);
    checks++;
    if ({video_r, video_g, video_b, video_hblank, video_vblank} !== 26'h0) begin
      errors++;
      $display("FAIL reset_video got %h expected 0", {video_r, video_g, video_b, video_hblank, video_vblank});
    end
    cpu_read(2'd0, d);
    checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL reset_reg0 got %h expected 07", d); end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL reset_reg3 got %h expected 08", d); end
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_reg2 got %h expected 00", d); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_latency();
    pix_t e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        checks++;
        if ({video_r, video_g, video_b, video_hblank, video_vblank} !== e) begin
          errors++;
          $display("FAIL latency[%0d] got %h expected %h", i,
                   {video_r, video_g, video_b, video_hblank, video_vblank}, e);
        end
      end
      case (i)
        0: set_layers(24'h804020, 1, 24'h0, 0, 24'h0, 0, 0, 0);
        1: set_layers(24'h804020, 0, 24'h0, 0, 24'h0, 0, 0, 0);
        2: set_layers(24'h112233, 1, 24'h0, 0, 24'h0, 0, 1, 0);
        3: set_layers(24'h804020, 1, 24'h0, 0, 24'h0, 0, 0, 1);
        default: set_layers(24'h804020, 1, 24'h0, 0, 24'h0, 0, 0, 0);
      endcase
      exp_q.push_back(model_pixel());
    end
    exp_q.delete();
  endtask

  task automatic test_priority();
    pix_t e;
    for (int p = 0; p < 2; p++) begin
      m_reg0 = (p == 0) ? 4'h7 : 4'hF;
      cpu_write(2'd0, {4'h0, m_reg0});
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (exp_q.size() == 2) begin
          e = exp_q.pop_front();
          checks++;
          if ({video_r, video_g, video_b, video_hblank, video_vblank} !== e) begin
            errors++;
            $display("FAIL priority[reg0=%h,%0d] got %h expected %h", m_reg0, i,
                     {video_r, video_g, video_b, video_hblank, video_vblank}, e);
          end
        end
        if (i == 0)      set_layers(24'hFF0000, 1, 24'h0000FF, 0, 24'h00FF00, 1, 0, 0);
        else if (i == 1) set_layers(24'hFF0000, 1, 24'h0000FF, 1, 24'h00FF00, 1, 0, 0);
        else if (i < 14) set_random_layers();
        else             set_layers(24'h0, 0, 24'h0, 0, 24'h0, 0, 0, 0);
        exp_q.push_back(model_pixel());
      end
      exp_q.delete();
    end
  endtask

  task automatic test_background();
    pix_t e;
    for (int p = 0; p < 3; p++) begin
      m_reg1 = (p == 2) ? 8'($urandom) : 8'hE0;
      m_reg0 = (p == 0) ? 4'h7 : 4'h0;
      cpu_write(2'd1, m_reg1);
      cpu_write(2'd0, {4'h0, m_reg0});
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (exp_q.size() == 2) begin
          e = exp_q.pop_front();
          checks++;
          if ({video_r, video_g, video_b, video_hblank, video_vblank} !== e) begin
            errors++;
            $display("FAIL background[reg1=%h,%0d] got %h expected %h", m_reg1, i,
                     {video_r, video_g, video_b, video_hblank, video_vblank}, e);
          end
        end
        if (p == 0) set_layers(24'h123456, 0, 24'h654321, 0, 24'hABCDEF, 0, 0, 0);
        else        set_layers(24'($urandom), 1, 24'($urandom), 1, 24'($urandom), 1, 0, 0);
        exp_q.push_back(model_pixel());
      end
      exp_q.delete();
    end
    m_reg0 = 4'h7;
    cpu_write(2'd0, 8'h07);
  endtask

  task automatic test_level();
    pix_t e;
    logic [7:0] d;
    logic [7:0] wr_vals [4] = '{8'd4, 8'd0, 8'd12, 8'd5};
    int         exp_lv  [4] = '{4, 0, 8, 5};
    for (int p = 0; p < 4; p++) begin
      cpu_write(2'd3, wr_vals[p]);
      m_level = exp_lv[p];
      cpu_read(2'd3, d);
      checks++;
      if (d !== 8'(exp_lv[p])) begin
        errors++;
        $display("FAIL level_readback[wr=%0d] got %0d expected %0d", wr_vals[p], d, exp_lv[p]);
      end
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (exp_q.size() == 2) begin
          e = exp_q.pop_front();
          checks++;
          if ({video_r, video_g, video_b, video_hblank, video_vblank} !== e) begin
            errors++;
            $display("FAIL level[%0d,%0d] got %h expected %h", m_level, i,
                     {video_r, video_g, video_b, video_hblank, video_vblank}, e);
          end
        end
        if (i < 2) set_layers(24'hFFFFFF, 1, 24'h0, 0, 24'h0, 0, 0, 0);
        else       set_layers(24'($urandom), 1, 24'h0, 0, 24'h0, 0, 0, 0);
        exp_q.push_back(model_pixel());
      end
      exp_q.delete();
    end
    cpu_write(2'd3, 8'd8);
    m_level = 8;
  endtask

  task automatic test_fade();
    logic [7:0] d;
    set_layers(24'h0, 0, 24'h0, 0, 24'h0, 0, 0, 0);
    cpu_write(2'd2, 8'd1);
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'd1) begin errors++; $display("FAIL fade_cmd_reg2 got %0d expected 1", d); end

    vblank_pulse();
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'd8) begin errors++; $display("FAIL fade_edge1 got %0d expected 8", d); end
    vblank_pulse();
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'd7) begin errors++; $display("FAIL fade_edge2 got %0d expected 7", d); end

    pause = 1'b1;
    repeat (3) vblank_pulse();
    pause = 1'b0;
    vblank_pulse();
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'd7) begin errors++; $display("FAIL fade_pause got %0d expected 7", d); end
    vblank_pulse();
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'd6) begin errors++; $display("FAIL fade_after_pause got %0d expected 6", d); end

    cpu_write(2'd2, 8'd2);
    cpu_write(2'd3, 8'd3);
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'd1) begin errors++; $display("FAIL fade_ignore_reg2 got %0d expected 1", d); end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'd6) begin errors++; $display("FAIL fade_ignore_reg3 got %0d expected 6", d); end

    for (int k = 1; k <= 12; k++) begin
      vblank_pulse();
      cpu_read(2'd3, d);
      checks++;
      if (d !== 8'(6 - k / 2)) begin
        errors++;
        $display("FAIL fade_out_edge[%0d] got %0d expected %0d", k, d, 6 - k / 2);
      end
    end
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'd0) begin errors++; $display("FAIL fade_out_done_reg2 got %0d expected 0", d); end

    // Fade out while already dark ends immediately
    cpu_write(2'd2, 8'd1);
    repeat (2) @(negedge clk);
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'd0) begin errors++; $display("FAIL fade_at_target_reg2 got %0d expected 0", d); end

    // Command write coincides with a vblank edge: that edge is not counted
    @(negedge clk);
    bus.addr = 2'd2; bus.data_in = 8'd2; bus.write = 1'b1; vblank = 1'b1;
    @(negedge clk);
    bus.write = 1'b0; vblank = 1'b0;
    vblank_pulse();
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'd0) begin errors++; $display("FAIL fade_in_same_edge got %0d expected 0", d); end
    vblank_pulse();
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'd1) begin errors++; $display("FAIL fade_in_step got %0d expected 1", d); end

    set_layers(24'hFFFFFF, 1, 24'h0, 0, 24'h0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (video_r !== 8'h1F) begin errors++; $display("FAIL fade_dim_pixel got %h expected 1f", video_r); end

    bus.addr = 2'd3;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({video_r, video_g, video_b, video_hblank, video_vblank} !== 26'h0) begin
      errors++;
      $display("FAIL async_reset_video got %h expected 0", {video_r, video_g, video_b, video_hblank, video_vblank});
    end
    checks++;
    if (bus.mixer_data_out !== 8'd8) begin
      errors++;
      $display("FAIL async_reset_level got %0d expected 8", bus.mixer_data_out);
    end
    @(negedge clk) reset_n = 1'b1;
    cpu_write(2'd3, 8'd5);
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'd5) begin errors++; $display("FAIL post_reset_idle got %0d expected 5", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.addr = '0;
    bus.data_in = '0;
    bus.write = 1'b0;
    test_reset();
    test_latency();
    test_priority();
    test_background();
    test_level();
    test_fade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
